chunked_zero_detect_ctrl: RTL and testbench
===========================================

# chunked_zero_detect_ctrl

Multi-cycle controller that decides whether a wide vector of `nbits*nchunks` bits is all-zero by time-sharing one `nbits`-wide NOR reduction unit across the chunks, one chunk per cycle. It also reports the index of the lowest nonzero chunk. It sits between a val/rdy producer and a val/rdy consumer and lets wide zero-detects reuse a narrow reduction datapath instead of a full-width tree.

## Interface
- `nbits`, default 8: width of one chunk, which is also the width of the NOR reduction; must be ≥1.
- `nchunks`, default 4: number of chunks per operation; must be ≥1.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_val`  input  1  request valid.
- `in_rdy`  output  1  controller can accept a request.
- `in_`  input  `nbits*nchunks`  vector to test; chunk k is `in_[k*nbits +: nbits]`.
- `out_val`  output  1  result valid.
- `out_rdy`  input  1  consumer accepts the result.
- `out_zero`  output  1  1 if the entire vector is zero.
- `out_idx`  output  `IW`  lowest nonzero chunk index; 0 when `out_zero`=1. `IW` = max(1, $clog2(nchunks)).
- `busy`  output  1  high in SCAN or DONE.

## Operation
- States: IDLE, SCAN, DONE. Counter `cnt` has width `IW`. The vector register holds `nbits*nchunks` bits.
- IDLE:
  - `in_rdy`=1, `out_val`=0.
  - On `in_val && in_rdy`: capture `in_` into the vector register, set `cnt`=0, go to SCAN.
- SCAN:
  - The NOR unit evaluates `~|chunk[cnt]` from the captured register only. `in_` is ignored after the handshake.
  - NOR=0 (chunk nonzero): `out_zero`←0, `out_idx`←`cnt`, go to DONE. This is an early exit; later chunks are not examined.
  - NOR=1 and `cnt`==nchunks-1: `out_zero`←1, `out_idx`←0, go to DONE.
  - NOR=1 otherwise: `cnt`←`cnt`+1, stay in SCAN.
- DONE:
  - `out_val`=1, with `out_zero`/`out_idx` held stable.
  - On `out_rdy`: go to IDLE.
  - No IDLE bypass: DONE never goes directly to SCAN.
- `in_rdy` = (state==IDLE) && !reset. `out_val` = (state==DONE). `busy` = (state!=IDLE).
- `out_zero` and `out_idx` are registered and change only on the SCAN→DONE transition.
- `cnt` never wraps: SCAN exits at `cnt`==nchunks-1 at the latest.
- nchunks=1: SCAN lasts exactly one cycle; `out_idx` is always 0.

## Timing
- Reset values, applied immediately while `reset` is high:
  - state IDLE, `cnt`=0, vector register 0.
  - `out_zero`=0, `out_idx`=0, `out_val`=0, `busy`=0, `in_rdy`=0.
  - `in_rdy` rises in the first cycle after `reset` deasserts.
- Handshake accepted at the edge ending cycle 0:
  - SCAN occupies cycle 1 onward; chunk k is evaluated in cycle k+1.
  - Lowest nonzero chunk k: `out_val` is high from cycle k+2.
  - All-zero vector: `out_val` is high from cycle nchunks+1.
- Result handshake in cycle t: IDLE in cycle t+1, `in_rdy`=1. The next request can be accepted in cycle t+1.
- Minimum issue interval: k+3 cycles for a nonzero vector, nchunks+2 for an all-zero vector.
- While `out_val`=1 and `out_rdy`=0: all outputs are held indefinitely and `in_rdy` stays 0.
- Reset mid-SCAN or mid-DONE: the operation is aborted and no result is produced. `out_val` drops asynchronously.
- `in_val` high while `in_rdy`=0 has no effect; the producer must hold its request.

## Test plan
- nbits=8, nchunks=4, `in_`=0x00000000, `out_rdy`=1 → `out_val` in cycle 5, `out_zero`=1, `out_idx`=0; `in_rdy`=1 in cycle 6.
- `in_`=0x00010000 → `out_val` in cycle 4, `out_zero`=0, `out_idx`=2. Then `in_`=0x80000000 → `out_idx`=3, `out_val` 5 cycles after accept.
- `in_`=0x00000001 → `out_val` in cycle 2, `out_idx`=0. Change `in_` to 0 in cycle 1 → result unchanged.
- `out_rdy` low for 3 cycles in DONE → `out_val`, `out_zero`, `out_idx` stable; `in_rdy`=0 throughout; `in_val` pulses ignored; accept on 4th cycle → IDLE next cycle.
- Assert `reset` in cycle 2 of an all-zero scan → outputs go to reset values immediately, no `out_val`. After deassert, a new `in_`=0x00000100 → `out_idx`=1.
- nchunks=1, nbits=5: `in_`=0 → `out_zero`=1 in cycle 2; `in_`=5'h10 → `out_zero`=0, `out_idx`=0 in cycle 2.

Source files
------------

// File: rtl/chunked_zero_detect_ctrl.sv
// chunked_zero_detect_ctrl
//   Decides whether a nbits*nchunks-bit vector is all-zero by running one
//   nbits-wide NOR reduction over the captured vector, one chunk per cycle,
//   and reports the index of the lowest nonzero chunk.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_val/in_rdy   request handshake; in_ is the vector to test
//   out_val/out_rdy result handshake; out_zero/out_idx are the result
//   busy            high while a request is being scanned or held in DONE
module chunked_zero_detect_ctrl #(
  parameter int unsigned nbits   = 8,
  parameter int unsigned nchunks = 4,
  localparam int unsigned IW     = (nchunks > 1) ? $clog2(nchunks) : 1,
  localparam int unsigned VW     = nbits * nchunks
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [VW-1:0] in_,
  output logic          out_val,
  input  logic          out_rdy,
  output logic          out_zero,
  output logic [IW-1:0] out_idx,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(nchunks - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            zero_q, zero_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            chunk_nz_c;

  // Shared reduction unit: OR of the chunk selected by cnt (NOR = ~chunk_nz_c)
  always_comb begin
    chunk_nz_c = 1'b0;
    for (int k = 0; k < int'(nchunks); k++) begin
      if (cnt_q == IW'(k)) chunk_nz_c = |vec_q[k*nbits +: nbits];
    end
  end

  // Next-state and result computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_val && in_rdy) begin
          vec_d   = in_;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chunk_nz_c) begin
          // Early exit on the lowest nonzero chunk
          zero_d  = 1'b0;
          idx_d   = cnt_q;
          state_d = S_DONE;
        end else if (cnt_q == LAST_IDX) begin
          zero_d  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  // in_rdy is gated by reset so the producer sees no acceptance during reset
  assign in_rdy   = (state_q == S_IDLE) && !reset;
  assign out_val  = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign out_zero = zero_q;
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_chunked_zero_detect_ctrl.sv
// Bench for chunked_zero_detect_ctrl: a 8x4 instance and a 5x1 instance,
// expected results queued at request acceptance and compared at result time.
module tb_chunked_zero_detect_ctrl;

  localparam int NB = 8;
  localparam int NC = 4;

  typedef struct {
    logic       zero;
    logic [1:0] idx;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_val0, in_rdy0, out_val0, out_rdy0, out_zero0, busy0;
  logic [31:0] in0;
  logic [1:0]  out_idx0;

  logic        in_val1, in_rdy1, out_val1, out_rdy1, out_zero1, busy1;
  logic [4:0]  in1;
  logic [0:0]  out_idx1;

  int   tests = 0;
  int   fails = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  chunked_zero_detect_ctrl #(.nbits(NB), .nchunks(NC)) dut0 (
    .clk(clk), .reset(reset), .in_val(in_val0), .in_rdy(in_rdy0), .in_(in0),
    .out_val(out_val0), .out_rdy(out_rdy0), .out_zero(out_zero0),
    .out_idx(out_idx0), .busy(busy0)
  );

  chunked_zero_detect_ctrl #(.nbits(5), .nchunks(1)) dut1 (
    .clk(clk), .reset(reset), .in_val(in_val1), .in_rdy(in_rdy1), .in_(in1),
    .out_val(out_val1), .out_rdy(out_rdy1), .out_zero(out_zero1),
    .out_idx(out_idx1), .busy(busy1)
  );

  // Reference: lowest nonzero chunk, latency from the accept cycle
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    e.zero = 1'b1;
    e.idx  = 2'd0;
    e.lat  = NC + 1;
    for (int k = NC - 1; k >= 0; k--) begin
      if (v[k*NB +: NB] != 8'h00) begin
        e.zero = 1'b0;
        e.idx  = 2'(k);
        e.lat  = k + 2;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_val0 = 1'b0; in0 = '0; out_rdy0 = 1'b0;
    in_val1 = 1'b0; in1 = '0; out_rdy1 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_val0, busy0, in_rdy0, out_zero0, out_idx0} !== 6'b0) begin
      fails++;
      $display("FAIL reset_state0: got %b expected 000000",
               {out_val0, busy0, in_rdy0, out_zero0, out_idx0});
    end
    tests++;
    if ({out_val1, busy1, in_rdy1, out_zero1, out_idx1} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state1: got %b expected 00000",
               {out_val1, busy1, in_rdy1, out_zero1, out_idx1});
    end
    reset = 1'b0;
    #1;
    tests++;
    if (in_rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL rdy_after_reset: got %b expected 1", in_rdy0);
    end
  endtask

  // One request on dut0; `after` replaces in_ right after the accept edge
  task automatic run_op(input logic [31:0] v, input logic [31:0] after, input int stall);
    exp_t e;
    int   lat;
    bit   got;
    logic hz;
    logic [1:0] hi;
    @(negedge clk);
    tests++;
    if (in_rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL in_rdy_idle: got %b expected 1", in_rdy0);
    end
    in_val0  = 1'b1;
    in0      = v;
    out_rdy0 = (stall == 0);
    sb0.push_back(model(v));
    @(posedge clk);
    #1;
    in_val0 = 1'b0;
    in0     = after;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_val0 === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL out_val_timeout: got 0 expected 1 within 20 cycles");
      sb0.delete();
    end else begin
      e = sb0.pop_front();
      tests++;
      if (lat !== e.lat) begin
        fails++;
        $display("FAIL latency v=%h: got %0d expected %0d", v, lat, e.lat);
      end
      tests++;
      if (out_zero0 !== e.zero) begin
        fails++;
        $display("FAIL out_zero v=%h: got %b expected %b", v, out_zero0, e.zero);
      end
      tests++;
      if (out_idx0 !== e.idx) begin
        fails++;
        $display("FAIL out_idx v=%h: got %0d expected %0d", v, out_idx0, e.idx);
      end
      hz = out_zero0;
      hi = out_idx0;
      // Backpressure: result must hold and requests must be refused
      for (int s = 0; s < stall; s++) begin
        in_val0 = (s % 2 == 0);
        in0     = 32'hFFFF_FFFF;
        @(negedge clk);
        tests++;
        if ({out_val0, in_rdy0, out_zero0, out_idx0} !== {1'b1, 1'b0, hz, hi}) begin
          fails++;
          $display("FAIL stall_hold: got %b expected %b",
                   {out_val0, in_rdy0, out_zero0, out_idx0}, {1'b1, 1'b0, hz, hi});
        end
      end
      in_val0 = 1'b0;
    end
    out_rdy0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({out_val0, in_rdy0, busy0} !== 3'b010) begin
      fails++;
      $display("FAIL back_to_idle: got %b expected 010", {out_val0, in_rdy0, busy0});
    end
  endtask

  task automatic test_directed();
    run_op(32'h0000_0000, 32'h0000_0000, 0);
    run_op(32'h0001_0000, 32'h0000_0000, 0);
    run_op(32'h8000_0000, 32'h0000_0000, 0);
    run_op(32'h0000_0001, 32'h0000_0000, 0);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_backpressure();
    run_op(32'h0040_0000, 32'h0000_0000, 3);
    run_op(32'h0000_0000, 32'h0000_0000, 3);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    in_val0 = 1'b1;
    in0     = 32'h0;
    sb0.push_back(model(32'h0));
    @(posedge clk);
    #1;
    in_val0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    sb0.delete();
    tests++;
    if ({out_val0, busy0, in_rdy0, out_zero0, out_idx0} !== 6'b0) begin
      fails++;
      $display("FAIL reset_mid_scan: got %b expected 000000",
               {out_val0, busy0, in_rdy0, out_zero0, out_idx0});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_val0 !== 1'b0 || in_rdy0 !== 1'b1) begin
        fails++;
        $display("FAIL no_result_after_abort: got val=%b rdy=%b expected val=0 rdy=1",
                 out_val0, in_rdy0);
      end
    end
    run_op(32'h0000_0100, 32'h0000_0000, 0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    int sh;
    for (int i = 0; i < 10; i++) begin
      v  = $urandom;
      sh = $urandom_range(0, 4);
      v  = (sh == 4) ? 32'h0 : (v & (32'hFFFF_FFFF << (sh * 8)));
      run_op(v, $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic run_op1(input logic [4:0] v);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    in_val1  = 1'b1;
    in1      = v;
    out_rdy1 = 1'b1;
    e.zero = (v == 5'd0);
    e.idx  = 2'd0;
    e.lat  = 2;
    sb1.push_back(e);
    @(posedge clk);
    #1;
    in_val1 = 1'b0;
    in1     = ~v;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_val1 === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL single_timeout: got 0 expected 1 within 10 cycles");
      sb1.delete();
    end else begin
      e = sb1.pop_front();
      tests++;
      if ({lat == e.lat, out_zero1, out_idx1} !== {1'b1, e.zero, 1'b0}) begin
        fails++;
        $display("FAIL single_chunk v=%h: got lat=%0d zero=%b idx=%0d expected lat=%0d zero=%b idx=0",
                 v, lat, out_zero1, out_idx1, e.lat, e.zero);
      end
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (in_rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL single_idle: got %b expected 1", in_rdy1);
    end
  endtask

  task automatic test_single_chunk();
    run_op1(5'h00);
    run_op1(5'h10);
    run_op1(5'h01);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
